// File: rtl/weight_stream_loader.sv
// weight_stream_loader: packs a byte stream little-endian into 32-bit weight writes.
// Define WEIGHT_STREAM_LOADER_CHECKSUM_EN to add a running 32-bit checksum output.
module weight_stream_loader #(
  parameter int unsigned NUM_WORDS = 77,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       weight_wr_data,
  output logic [ADDR_W-1:0] weight_wr_addr,
  output logic              weight_wr_en,
  output logic              busy,
  output logic              done
`ifdef WEIGHT_STREAM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned CNT_W =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD =
    CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

  logic [1:0]        state;
  logic [1:0]        byte_cnt;
  logic [CNT_W-1:0]  word_cnt;
  logic [23:0]       shreg;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              word_end;
  logic              last_word;
  logic              start_load;
  logic [31:0]       word;

  assign s_ready    = (state == LOAD);
  assign busy       = (state == LOAD);
  assign done       = (state == DONE);
  assign accept     = s_valid & s_ready;
  assign word_end   = accept & (byte_cnt == 2'd3);
  assign last_word  = (word_cnt == LAST_WORD);
  assign start_load = start & (state != LOAD);
  // The fourth byte goes straight into the word, never into shreg.
  assign word       = {s_data, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (word_end && last_word) state <= DONE;
        end
        DONE: begin
          if (start) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= 2'd0;
      word_cnt  <= '0;
      shreg     <= 24'd0;
      next_addr <= '0;
    end else if (start_load) begin
      byte_cnt  <= 2'd0;
      word_cnt  <= '0;
      shreg     <= 24'd0;
      next_addr <= BASE;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      unique case (byte_cnt)
        2'd0: shreg[7:0]   <= s_data;
        2'd1: shreg[15:8]  <= s_data;
        2'd2: shreg[23:16] <= s_data;
        2'd3: begin
          word_cnt  <= word_cnt + CNT_W'(1);
          next_addr <= next_addr + ADDR_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_wr_en   <= 1'b0;
      weight_wr_data <= 32'd0;
      weight_wr_addr <= '0;
    end else begin
      weight_wr_en <= word_end;
      if (word_end) begin
        weight_wr_data <= word;
        weight_wr_addr <= next_addr;
      end
    end
  end

`ifdef WEIGHT_STREAM_LOADER_CHECKSUM_EN
  // Summed at byte acceptance so the total is final when done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= 32'd0;
    end else if (start_load) begin
      checksum <= 32'd0;
    end else if (word_end) begin
      checksum <= checksum + word;
    end
  end
`endif

endmodule

// File: doc/weight_stream_loader.md
Name: weight_stream_loader

Overview:
- Master-side driver of the conv layer weight-write port (weight_wr_data / weight_wr_addr / weight_wr_en).
- Accepts a byte stream of packed layer parameters (kernels, biases, MACC coefficients) from a host/DMA FIFO with valid/ready handshake.
- Packs bytes little-endian into 32-bit words and issues one write per word at consecutive word addresses.
- Signals completion once NUM_WORDS words have been written; sits between the host loader FIFO and the model top.

Parameters:
- NUM_WORDS, 77, total words to write per load (72 kernel + 4 bias + 1 macc_coeff).
- BASE_ADDR, 0, word address of the first write.
- ADDR_W, 32, width of weight_wr_addr.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse, begins a load.
- s_data  input  8  parameter byte stream.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts byte this cycle.
- weight_wr_data  output  32  assembled word.
- weight_wr_addr  output  ADDR_W  word address.
- weight_wr_en  output  1  one-cycle write strobe.
- busy  output  1  high while in LOAD.
- done  output  1  high in DONE state.

Behaviour:
- Reset (async, rst_n=0): state IDLE; s_ready=0, weight_wr_en=0, weight_wr_data=0, weight_wr_addr=0, busy=0, done=0, byte counter=0, word counter=0.
- States: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD; word counter=0, byte counter=0, next address=BASE_ADDR.
  - LOAD: s_ready=1 (combinational from state only, independent of s_valid). A byte is accepted when s_valid & s_ready.
  - LOAD: accepted byte k (k=0..3) lands in shift-register bits [8k+7:8k].
  - LOAD: on acceptance of byte 3, the next cycle drives weight_wr_en=1 for exactly one cycle, with weight_wr_data = assembled word and weight_wr_addr = BASE_ADDR + word index. Byte-to-write latency is 1 cycle.
  - LOAD: accepting the last byte of word NUM_WORDS-1 moves the state to DONE in the same edge that registers the final write. s_ready falls on that edge, so no extra byte is accepted.
  - DONE: done=1, s_ready=0. start=1 -> LOAD, with counters cleared and done falling.
- Outside write cycles, weight_wr_en=0; weight_wr_data and weight_wr_addr hold their last values.
- start while in LOAD is ignored; the load is not restarted.
- s_valid gaps: the partial word is held indefinitely with no timeout.
- s_valid in IDLE or DONE: s_ready=0, so bytes are not consumed.
- Address arithmetic: unsigned, ADDR_W wide, wraps modulo 2^ADDR_W (no saturation).
- busy = (state==LOAD); done = (state==DONE). Both are registered state decodes.
- Reset mid-load: all state is discarded and returns to IDLE. Any partially assembled word is never written.

Optional Feature:
- Macro: WEIGHT_STREAM_LOADER_CHECKSUM_EN.
- Defined: adds output port checksum [31:0]. It is cleared on start (IDLE->LOAD or DONE->LOAD) and accumulates (modulo 2^32) every weight_wr_data on cycles where weight_wr_en=1. It is stable and valid while done=1, and reset value is 0.
- Undefined: no checksum port or logic; all other behaviour is identical.

Test Plan:
- Basic load, NUM_WORDS=3, BASE_ADDR=0: start, then bytes 01 02 03 04 05 06 07 08 09 0A 0B 0C with s_valid continuous -> writes (addr 0, 0x04030201), (addr 1, 0x08070605), (addr 2, 0x0C0B0A09), each one cycle after its 4th byte. done=1 the cycle after the last byte; s_ready=0 thereafter.
- Gapped stream: s_valid toggled 1/0 every cycle -> same three writes and values. weight_wr_en never asserts for a partial word.
- BASE_ADDR=72, NUM_WORDS=5 -> write addresses 72..76 in order. busy=1 from the cycle after start until done rises.
- Restart and ignored start: start pulsed mid-load -> no effect on the address sequence. Second start from DONE -> addresses restart at BASE_ADDR and done clears.
- Reset mid-load: assert rst_n=0 after 6 bytes -> all outputs 0 asynchronously. After release, a new load writes from BASE_ADDR and no stale write occurs.
- Checksum (macro defined): words 0x00000001, 0xFFFFFFFF, 0x00000005 -> checksum=0x00000005 while done=1.
